// File: rtl/game_pkg.sv
// Shared types and key codes for the sprite game logic.
// Imported by the mover and its per-axis clamp.
package game_pkg;

  typedef enum logic [1:0] {
    GROUNDED,
    RISING,
    FALLING
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

endpackage

// File: rtl/axis_clamp.sv
// One axis of motion: sign-extended position + velocity,
// bound compare and clamp against the playfield edges.
module axis_clamp #(
  parameter int W    = 10,
  parameter int LO   = 0,
  parameter int HI   = 639,
  parameter int SIZE = 16
) (
  input  logic [W-1:0]        pos,
  input  logic signed [W-1:0] vel,
  input  logic                lo_en,
  input  logic                hi_en,
  output logic [W-1:0]        nxt,
  output logic                hit_lo,
  output logic                hit_hi
);

  localparam int EW = W + 2;
  localparam logic signed [EW-1:0] LO_LIM = EW'(LO + SIZE);
  localparam logic signed [EW-1:0] HI_LIM = EW'(HI - SIZE);

  logic signed [EW-1:0] sum;

  // Two guard bits keep the sum from wrapping past either edge
  assign sum = $signed({2'b00, pos}) + $signed({{2{vel[W-1]}}, vel});

  assign hit_hi = hi_en && (sum >= HI_LIM);
  assign hit_lo = lo_en && (sum <= LO_LIM);

  assign nxt = hit_hi ? HI_LIM[W-1:0] :
               hit_lo ? LO_LIM[W-1:0] :
               sum[W-1:0];

endmodule

// File: rtl/sprite_mover.sv
// Frame-rate sprite physics: walk, jump, gravity, floor,
// ceiling and wall handling. One update per frame_clk edge.
module sprite_mover
  import game_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int SIZE      = 16,
  parameter int WALK_V    = 2,
  parameter int JUMP_V    = 10,
  parameter int VMAX      = 8,
  parameter int GRAVITY   = 1,
  parameter int GRAV_DIV  = 2,
  parameter int WALL_MODE = 0
) (
  input  logic                      frame_clk,
  input  logic                      Reset_n,
  input  logic [7:0]                keycode,
  output logic [COORD_W-1:0]        X,
  output logic [COORD_W-1:0]        Y,
  output logic [COORD_W-1:0]        S,
  output logic signed [COORD_W-1:0] Vx,
  output logic signed [COORD_W-1:0] Vy,
  output logic                      grounded,
  output logic                      wall_hit
);

  localparam int GW = $clog2(GRAV_DIV + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GRAV_DIV - 1);

  localparam logic signed [COORD_W-1:0] WALK = COORD_W'(WALK_V);
  localparam logic signed [COORD_W-1:0] JUMP = COORD_W'(JUMP_V);
  localparam logic signed [COORD_W-1:0] VLIM = COORD_W'(VMAX);
  localparam logic signed [COORD_W-1:0] GRAV = COORD_W'(GRAVITY);

  state_t                      state, st_n, st_f;
  logic [7:0]                  key_prev;
  logic [GW-1:0]               gc, gc_n, gc_f;
  logic                        jump, tick;
  logic signed [COORD_W-1:0]   vx_key, vy_g, vy_n, vy_f;
  logic [COORD_W-1:0]          x_nxt, y_nxt;
  logic                        x_lo, x_hi, y_lo, y_hi;

  assign S    = COORD_W'(SIZE);
  assign jump = (keycode == KEY_W) && (key_prev != KEY_W);
  assign tick = (gc == G_LAST);
  assign vy_g = Vy + GRAV;

  always_comb begin
    vx_key = '0;
    unique case (1'b1)
      keycode == KEY_A: vx_key = -WALK;
      keycode == KEY_D: vx_key = WALK;
      default:          vx_key = '0;
    endcase
  end

  always_comb begin
    st_n = state;
    vy_n = Vy;
    gc_n = '0;
    unique case (state)
      GROUNDED: begin
        vy_n = '0;
        if (jump) begin
          st_n = RISING;
          vy_n = -JUMP;
        end
      end
      RISING: begin
        gc_n = tick ? '0 : gc + 1'b1;
        if (keycode == KEY_S) begin
          st_n = FALLING;
          vy_n = '0;
        end else begin
          vy_n = tick ? vy_g : Vy;
          if (!vy_n[COORD_W-1]) st_n = FALLING;
        end
      end
      FALLING: begin
        gc_n = tick ? '0 : gc + 1'b1;
        if (tick) vy_n = (vy_g > VLIM) ? VLIM : vy_g;
      end
      default: st_n = FALLING;
    endcase
  end

  axis_clamp #(
    .W(COORD_W), .LO(X_MIN), .HI(X_MAX), .SIZE(SIZE)
  ) u_x (
    .pos(X), .vel(vx_key),
    .lo_en(vx_key < 0), .hi_en(vx_key > 0),
    .nxt(x_nxt), .hit_lo(x_lo), .hit_hi(x_hi)
  );

  axis_clamp #(
    .W(COORD_W), .LO(Y_MIN), .HI(Y_MAX), .SIZE(SIZE)
  ) u_y (
    .pos(Y), .vel(vy_n),
    .lo_en(st_n == RISING), .hi_en(st_n == FALLING),
    .nxt(y_nxt), .hit_lo(y_lo), .hit_hi(y_hi)
  );

  // Floor and ceiling contact override the gravity result
  always_comb begin
    st_f = st_n;
    vy_f = vy_n;
    gc_f = gc_n;
    if (y_hi) begin
      st_f = GROUNDED;
      vy_f = '0;
      gc_f = '0;
    end else if (y_lo) begin
      st_f = FALLING;
      vy_f = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      X        <= COORD_W'(X_CENTER);
      Y        <= COORD_W'(Y_CENTER);
      Vx       <= '0;
      Vy       <= '0;
      state    <= FALLING;
      grounded <= 1'b0;
      gc       <= '0;
      wall_hit <= 1'b0;
      key_prev <= '0;
    end else begin
      X        <= x_nxt;
      Y        <= y_nxt;
      Vy       <= vy_f;
      state    <= st_f;
      grounded <= (st_f == GROUNDED);
      gc       <= gc_f;
      key_prev <= keycode;
      wall_hit <= x_lo | x_hi;
      if (x_lo | x_hi)
        Vx <= (WALL_MODE != 0) ? -vx_key : '0;
      else
        Vx <= vx_key;
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: three instances (default,
// right-wall stop, left-wall reflect) checked against hand values.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] kc_a, kc_b, kc_c;

  logic [9:0]        xa, ya, sa, xb, yb, sb, xc, yc, sc;
  logic signed [9:0] vxa, vya, vxb, vyb, vxc, vyc;
  logic              ga, wa, gb, wb, gc, wc;

  always #5 clk = ~clk;

  sprite_mover dut_a (
    .frame_clk(clk), .Reset_n(rst_n), .keycode(kc_a),
    .X(xa), .Y(ya), .S(sa), .Vx(vxa), .Vy(vya),
    .grounded(ga), .wall_hit(wa)
  );

  sprite_mover #(.X_CENTER(621), .WALL_MODE(0)) dut_b (
    .frame_clk(clk), .Reset_n(rst_n), .keycode(kc_b),
    .X(xb), .Y(yb), .S(sb), .Vx(vxb), .Vy(vyb),
    .grounded(gb), .wall_hit(wb)
  );

  sprite_mover #(.X_CENTER(17), .WALL_MODE(1)) dut_c (
    .frame_clk(clk), .Reset_n(rst_n), .keycode(kc_c),
    .X(xc), .Y(yc), .S(sc), .Vx(vxc), .Vy(vyc),
    .grounded(gc), .wall_hit(wc)
  );

  typedef struct {
    int                cyc;
    int                inst;
    string             name;
    logic [5:0]        m;
    logic [9:0]        x;
    logic [9:0]        y;
    logic signed [9:0] vx;
    logic signed [9:0] vy;
    logic              g;
    logic              w;
  } exp_t;

  // mask bits: x, y, vx, vy, grounded, wall_hit
  localparam logic [5:0] M_ALL = 6'b111111;
  localparam logic [5:0] M_X   = 6'b101011;
  localparam logic [5:0] M_Y   = 6'b010111;

  exp_t exp_q[$];
  int   cyc = -3;
  int   vectors = 0;
  int   errors = 0;

  task automatic exp_push(input int c, input int inst,
                          input string nm, input logic [5:0] m,
                          input int x, input int y, input int vx,
                          input int vy, input bit g, input bit w);
    exp_t e;
    e.cyc = c; e.inst = inst; e.name = nm; e.m = m;
    e.x = 10'(x); e.y = 10'(y);
    e.vx = 10'(vx); e.vy = 10'(vy);
    e.g = g; e.w = w;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic compare(input exp_t e);
    logic [9:0]        x, y, s;
    logic signed [9:0] vx, vy;
    logic              g, w;
    bit                bad;
    case (e.inst)
      0: begin x = xa; y = ya; s = sa; vx = vxa; vy = vya; g = ga; w = wa; end
      1: begin x = xb; y = yb; s = sb; vx = vxb; vy = vyb; g = gb; w = wb; end
      default: begin x = xc; y = yc; s = sc; vx = vxc; vy = vyc; g = gc; w = wc; end
    endcase
    bad = (s !== 10'd16);
    if (e.m[5] && x  !== e.x)  bad = 1;
    if (e.m[4] && y  !== e.y)  bad = 1;
    if (e.m[3] && vx !== e.vx) bad = 1;
    if (e.m[2] && vy !== e.vy) bad = 1;
    if (e.m[1] && g  !== e.g)  bad = 1;
    if (e.m[0] && w  !== e.w)  bad = 1;
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL %s cyc=%0d got X=%0d Y=%0d S=%0d Vx=%0d Vy=%0d g=%b w=%b want X=%0d Y=%0d Vx=%0d Vy=%0d g=%b w=%b mask=%b",
               e.name, cyc, x, y, s, vx, vy, g, w,
               e.x, e.y, e.vx, e.vy, e.g, e.w, e.m);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; check anything due now
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        compare(exp_q[i]);
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        vectors++;
        errors++;
        $display("FAIL %s missed at cyc=%0d want cyc=%0d",
                 exp_q[i].name, cyc, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    kc_a = 8'h00; kc_b = 8'h00; kc_c = 8'h00;
    step(); step(); step();
    exp_push(0, 0, "reset_a", M_ALL, 320, 240, 0, 0, 0, 0);
    exp_push(0, 1, "reset_b", M_ALL, 621, 240, 0, 0, 0, 0);
    exp_push(0, 2, "reset_c", M_ALL, 17, 240, 0, 0, 0, 0);

    rst_n = 1'b1;
    kc_b = 8'h07;
    kc_c = 8'h04;
    exp_push(1, 1, "wall_stop_hit", M_X, 623, 0, 0, 0, 0, 1);
    exp_push(1, 2, "wall_reflect_hit", M_X, 16, 0, 2, 0, 0, 1);
    exp_push(16, 0, "fall_vy8", M_ALL, 320, 304, 0, 8, 0, 0);
    exp_push(17, 0, "fall_sat", M_ALL, 320, 312, 0, 8, 0, 0);
    exp_push(35, 0, "fall_pre_land", M_ALL, 320, 456, 0, 8, 0, 0);
    exp_push(36, 0, "land", M_ALL, 320, 463, 0, 0, 1, 0);

    step();
    kc_b = 8'h00;
    exp_push(2, 1, "wall_stop_pulse_end", M_X, 623, 0, 0, 0, 0, 0);
    exp_push(2, 2, "wall_reflect_again", M_X, 16, 0, 2, 0, 0, 1);

    step();
    kc_b = 8'h04;
    kc_c = 8'h07;
    exp_push(3, 1, "walk_left_off_wall", M_X, 621, 0, -2, 0, 0, 0);
    exp_push(3, 2, "walk_right_off_wall", M_X, 18, 0, 2, 0, 0, 0);

    while (cyc < 36) step();
    kc_a = 8'h1A;
    exp_push(37, 0, "jump", M_ALL, 320, 453, 0, -10, 0, 0);
    exp_push(39, 0, "rise_tick", M_Y, 0, 434, 0, -9, 0, 0);
    exp_push(57, 0, "apex", M_Y, 0, 353, 0, 0, 0, 0);
    exp_push(73, 0, "fall2_vy8", M_Y, 0, 417, 0, 8, 0, 0);
    exp_push(79, 0, "land2", M_ALL, 320, 463, 0, 0, 1, 0);
    exp_push(80, 0, "held_w_no_jump", M_Y, 0, 463, 0, 0, 1, 0);
    exp_push(85, 0, "held_w_still", M_ALL, 320, 463, 0, 0, 1, 0);

    while (cyc < 85) step();
    kc_a = 8'h00;
    step();
    kc_a = 8'h1A;
    exp_push(87, 0, "jump2", M_Y, 0, 453, 0, -10, 0, 0);
    step();
    kc_a = 8'h16;
    exp_push(88, 0, "s_cancel", M_Y, 0, 453, 0, 0, 0, 0);
    exp_push(89, 0, "s_fall_tick", M_Y, 0, 454, 0, 1, 0, 0);
    exp_push(94, 0, "land3", M_Y, 0, 463, 0, 0, 1, 0);

    while (cyc < 94) step();
    kc_a = 8'h00;
    step();
    kc_a = 8'h1A;
    exp_push(96, 0, "jump3", M_Y, 0, 453, 0, -10, 0, 0);
    step();
    rst_n = 1'b0;
    exp_push(97, 0, "reset_mid_jump", M_ALL, 320, 240, 0, 0, 0, 0);
    exp_push(97, 1, "reset_b_again", M_ALL, 621, 240, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    kc_a = 8'h00;
    step(); step();

    foreach (exp_q[i]) begin
      vectors++;
      errors++;
      $display("FAIL %s never checked, due cyc=%0d",
               exp_q[i].name, exp_q[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-002 SHALL have parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 0/639/0/479, playfield bounds (inclusive).
REQ-003 SHALL have parameters X_CENTER/Y_CENTER, defaults 320/240, reset position.
REQ-004 SHALL have parameter SIZE, default 16, sprite half-extent in pixels.
REQ-005 SHALL have parameters WALK_V, JUMP_V, VMAX, GRAVITY, defaults 2, 10, 8, 1, speeds in px/frame.
REQ-006 SHALL have parameter GRAV_DIV, default 2, frames per gravity increment (>=1).
REQ-007 SHALL have parameter WALL_MODE, default 0: 0 = stop at wall, 1 = reflect.
REQ-008 SHALL have ports: frame_clk in 1 (sole clock, one update per edge); Reset_n in 1 (synchronous, active-low); keycode in 8 (USB HID code).
REQ-009 SHALL have outputs X, Y out COORD_W (sprite centre); S out COORD_W (= SIZE); Vx, Vy out signed COORD_W (velocity); grounded out 1; wall_hit out 1 (one-cycle pulse).

Function
REQ-010 SHALL implement state machine GROUNDED, RISING, FALLING; grounded = (state == GROUNDED).
REQ-011 SHALL detect a jump press only on keycode changing to 8'h1A from any other value (previous keycode registered); held W SHALL NOT re-jump.
REQ-012 GROUNDED + jump press -> RISING, Vy = -JUMP_V, gravity counter cleared.
REQ-013 RISING: Vy += GRAVITY on each gravity tick; when next Vy >= 0 -> FALLING.
REQ-014 RISING + keycode 8'h16 (S) -> FALLING with Vy = 0 next cycle.
REQ-015 FALLING: Vy += GRAVITY on each gravity tick, saturating at +VMAX.
REQ-016 Gravity tick SHALL occur when the counter (0..GRAV_DIV-1) equals GRAV_DIV-1; counter wraps to 0; it runs only in RISING/FALLING and holds 0 in GROUNDED.
REQ-017 Vx SHALL be -WALK_V for 8'h04 (A), +WALK_V for 8'h07 (D), else 0, in all states.
REQ-018 Next position SHALL be X+Vx, Y+Vy, computed sign-extended to COORD_W+2 bits; no wrap-around permitted.
REQ-019 If Y_next+SIZE >= Y_MAX while falling: Y = Y_MAX-SIZE, Vy = 0, -> GROUNDED.
REQ-020 If Y_next-SIZE <= Y_MIN while rising: Y = Y_MIN+SIZE, Vy = 0, -> FALLING.
REQ-021 If X_next+SIZE >= X_MAX or X_next-SIZE <= X_MIN: X clamped to X_MAX-SIZE / X_MIN+SIZE; wall_hit = 1 next cycle; Vx = 0 (WALL_MODE 0) or -Vx (WALL_MODE 1, held for that update only).
REQ-022 Boundary clamps SHALL take priority over key-derived velocity in the same cycle.
REQ-023 Jump press and S key in the same cycle: jump wins in GROUNDED.
REQ-024 All outputs SHALL be registered; key effect visible on the next frame_clk edge (latency 1).

Reset
REQ-025 On Reset_n = 0 at a frame_clk edge: X = X_CENTER, Y = Y_CENTER, Vx = Vy = 0, state = FALLING, gravity counter = 0, wall_hit = 0, previous keycode = 0.
REQ-026 Reset mid-jump SHALL abandon motion and apply REQ-025 values in the same cycle.

Structure
REQ-027 SHALL place the state enum and keycode constants (KEY_W/A/S/D) in shared package game_pkg.
REQ-028 SHALL use one sub-module, axis_clamp, performing the sign-extended add, bound compare and clamp for one axis (instantiated twice).

Verification
REQ-029 Reset, keycode 0 -> after reset X=320, Y=240, FALLING; Vy reaches 8 and saturates; lands with Y=463, Vy=0, grounded=1.
REQ-030 Grounded, keycode 00->1A -> next cycle Vy=-10, Y=453, RISING; held 1A after landing -> no second jump.
REQ-031 RISING, keycode 16 -> next cycle FALLING, Vy=0.
REQ-032 WALL_MODE=0, X=621, keycode 07 -> X=623, Vx=0, wall_hit pulses exactly one cycle.
REQ-033 WALL_MODE=1, X=17, keycode 04 -> X=16, Vx=+2, wall_hit=1.
REQ-034 Reset_n=0 during RISING -> all REQ-025 values on the next edge.
